fifo_uart_sender: RTL and testbench

- Drains the FIR output FIFO toward the PC over the UART transmitter; this is the transmit-side counterpart of the coefficient byte-to-word receive path.
- On a send request it pops DATA_W-bit samples from the FIFO and splits each into bytes, MSB byte first.
- Each byte is handed to the UART TX through a start/busy handshake, and the block stops when the FIFO reads empty at a sample boundary.

---
 rtl/fifo_uart_sender.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_sender.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_sender.sv
// fifo_uart_sender: drains DATA_W-bit samples from the FIR output FIFO and sends
// each one to the UART transmitter as NBYTES bytes, most significant byte first.
// Define FIFO_SENDER_HEADER_EN to prefix every drain with a single 0xA5 header byte.
module fifo_uart_sender #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned SIGN_EXT = 1,
  parameter int unsigned CNT_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              send_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o
);

  localparam int unsigned NBYTES = (DATA_W + 7) / 8;
  localparam int unsigned PAD_W  = 8 * NBYTES;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [7:0] HEADER = 8'hA5;

`ifdef FIFO_SENDER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StRd, StLatch, StSend, StAck, StWait, StNext
  } state_e;

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         txd_q, txd_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;   // one ACK cycle already spent waiting for busy
  logic               hdr_q, hdr_d;   // current byte is the header, not sample data

  logic [PAD_W-1:0]   pad_data;
  logic [PAD_W-1:0]   sr_shifted;
  logic [7:0]         sel_byte;

  // Pad the incoming sample to whole bytes and pick the byte addressed by idx_q
  always_comb begin
    pad_data   = (SIGN_EXT != 0) ? PAD_W'($signed(fifo_data_i)) : PAD_W'(fifo_data_i);
    sr_shifted = sr_q >> {idx_q, 3'b000};
    sel_byte   = hdr_q ? HEADER : sr_shifted[7:0];
  end

  // Handshake outputs; tx_data_o shows the new byte in its strobe cycle, then holds it
  always_comb begin
    tx_start_o   = (state_q == StSend) && !tx_busy_i;
    tx_data_o    = tx_start_o ? sel_byte : txd_q;
    fifo_rd_o    = (state_q == StRd) && !fifo_empty_i;
    busy_o       = (state_q != StIdle);
    done_o       = done_q;
    sample_cnt_o = cnt_q;
  end

  // Next-state logic for the drain sequencer
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    hdr_d   = hdr_q;
    unique case (state_q)
      StIdle: begin
        if (send_i) begin
          cnt_d = '0;
          if (HDR_EN) begin
            hdr_d   = 1'b1;
            state_d = StSend;
          end else if (fifo_empty_i) begin
            done_d = 1'b1;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        // Empty here can only follow an external FIFO flush; finish cleanly
        state_d = fifo_empty_i ? StNext : StLatch;
      end
      StLatch: begin
        sr_d    = pad_data;
        idx_d   = LAST_IDX;
        state_d = StSend;
      end
      StSend: begin
        if (!tx_busy_i) begin
          txd_d   = sel_byte;
          ack_d   = 1'b0;
          state_d = StAck;
        end
      end
      StAck: begin
        // Second ACK cycle without busy: assume the UART took the byte anyway
        if (tx_busy_i || ack_q) begin
          state_d = StWait;
        end else begin
          ack_d = 1'b1;
        end
      end
      StWait: begin
        if (!tx_busy_i) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = StNext;
          end else if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            state_d = StSend;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (!fifo_empty_i) begin
          state_d = StRd;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      hdr_q   <= hdr_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_sender.sv
// Bench for fifo_uart_sender: one sign-extending and one zero-padding instance share
// the same FIFO and UART models; the expected byte stream comes from sample values.
module tb_fifo_uart_sender;

  localparam int DW = 12;
  localparam int NB = (DW + 7) / 8;
`ifdef FIFO_SENDER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          send;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic          tx_busy;

  logic       rd_s, start_s, busy_s, done_s;
  logic [7:0] data_s;
  logic [9:0] cnt_s;
  logic       rd_z, start_z, busy_z, done_z;
  logic [7:0] data_z;
  logic [9:0] cnt_z;

  always #5 clk = ~clk;

  fifo_uart_sender #(.DATA_W(DW), .SIGN_EXT(1), .CNT_W(10)) dut_s (
    .clk_i(clk), .rst_i(rst), .send_i(send), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_rd_o(rd_s), .tx_data_o(data_s), .tx_start_o(start_s),
    .tx_busy_i(tx_busy), .busy_o(busy_s), .done_o(done_s), .sample_cnt_o(cnt_s)
  );

  fifo_uart_sender #(.DATA_W(DW), .SIGN_EXT(0), .CNT_W(10)) dut_z (
    .clk_i(clk), .rst_i(rst), .send_i(send), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_rd_o(rd_z), .tx_data_o(data_z), .tx_start_o(start_z),
    .tx_busy_i(tx_busy), .busy_o(busy_z), .done_o(done_z), .sample_cnt_o(cnt_z)
  );

  // FIFO model: memory written by the stimulus, read pointer advanced by dut_s
  logic [DW-1:0] mem [64];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  // UART model: busy for busy_len cycles after each start, or held by hold_busy
  int busy_cnt = 0;
  int busy_len = 10;
  bit hold_busy = 1'b0;
  assign tx_busy = hold_busy || (busy_cnt != 0);

  logic [7:0] q_s[$];
  logic [7:0] q_z[$];
  int n_rd_s = 0, n_rd_z = 0, n_done_s = 0, n_done_z = 0, bad = 0;

  // Observe handshakes and model the synchronous FIFO/UART peers
  always @(posedge clk) begin
    if (start_s) begin
      q_s.push_back(data_s);
      busy_cnt <= busy_len;
      if (tx_busy) bad <= bad + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (start_z) q_z.push_back(data_z);
    if (rd_s) begin
      fifo_data <= mem[rp % 64];
      rp        <= rp + 1;
      n_rd_s    <= n_rd_s + 1;
      if (fifo_empty) bad <= bad + 1;
    end
    if (rd_z) n_rd_z <= n_rd_z + 1;
    if (done_s) n_done_s <= n_done_s + 1;
    if (done_z) n_done_z <= n_done_z + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] pend_s[$];
  logic [7:0] pend_z[$];
  int b_qs, b_qz, b_rd_s, b_rd_z, b_done_s, b_done_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_put(input logic [DW-1:0] v);
    mem[wp % 64] = v;
    wp = wp + 1;
  endtask

  // Expected bytes: the sample as a signed or unsigned number, MSB byte first
  task automatic add_exp(input logic [DW-1:0] v);
    longint p_s, p_z;
    p_z = longint'(v);
    p_s = p_z;
    if (v[DW-1]) p_s = p_s - (longint'(1) << DW);
    for (int b = NB - 1; b >= 0; b--) begin
      pend_s.push_back(8'((p_s >> (8 * b)) & 255));
      pend_z.push_back(8'((p_z >> (8 * b)) & 255));
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_put(v);
    add_exp(v);
  endtask

  task automatic pulse_send();
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
  endtask

  task automatic start_drain();
    b_qs = q_s.size();  b_qz = q_z.size();
    b_rd_s = n_rd_s;    b_rd_z = n_rd_z;
    b_done_s = n_done_s; b_done_z = n_done_z;
    pulse_send();
  endtask

  task automatic finish_drain(input int nsamp, input string tag);
    logic [7:0] e_s[$];
    logic [7:0] e_z[$];
    int k = 0;
    while (!done_s && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done_s, 1'b1);
    @(negedge clk);
    e_s = {};
    e_z = {};
    if (HDR) begin
      e_s.push_back(8'hA5);
      e_z.push_back(8'hA5);
    end
    foreach (pend_s[i]) e_s.push_back(pend_s[i]);
    foreach (pend_z[i]) e_z.push_back(pend_z[i]);
    chk({tag, "_nbytes_s"}, q_s.size() - b_qs, e_s.size());
    chk({tag, "_nbytes_z"}, q_z.size() - b_qz, e_z.size());
    foreach (e_s[i]) if (b_qs + i < q_s.size()) chk({tag, "_byte_s"}, q_s[b_qs + i], e_s[i]);
    foreach (e_z[i]) if (b_qz + i < q_z.size()) chk({tag, "_byte_z"}, q_z[b_qz + i], e_z[i]);
    chk({tag, "_reads_s"}, n_rd_s - b_rd_s, nsamp);
    chk({tag, "_reads_z"}, n_rd_z - b_rd_z, nsamp);
    chk({tag, "_cnt_s"}, cnt_s, nsamp);
    chk({tag, "_cnt_z"}, cnt_z, nsamp);
    chk({tag, "_ndone_s"}, n_done_s - b_done_s, 1);
    chk({tag, "_ndone_z"}, n_done_z - b_done_z, 1);
    chk({tag, "_idle"}, busy_s, 1'b0);
    pend_s = {};
    pend_z = {};
  endtask

  initial begin
    logic [DW-1:0] v1, v2;
    int n, k, s0, r0;
    rst  = 1'b1;
    send = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd", {rd_s, rd_z}, 2'b00);
    chk("rst_start", {start_s, start_z}, 2'b00);
    chk("rst_busy", {busy_s, busy_z}, 2'b00);
    chk("rst_done", {done_s, done_z}, 2'b00);
    chk("rst_data", {data_s, data_z}, 16'h0000);
    chk("rst_cnt", {cnt_s, cnt_z}, 20'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty FIFO request
    start_drain();
`ifndef FIFO_SENDER_HEADER_EN
    chk("empty_done_next_cycle", done_s, 1'b1);
`endif
    finish_drain(0, "empty");

    // Negative sample, sign-extended vs zero-padded
    busy_len = 10;
    push(12'h8F3);
    start_drain();
`ifndef FIFO_SENDER_HEADER_EN
    repeat (2) @(negedge clk);
    chk("first_start_latency", start_s, 1'b1);
`endif
    finish_drain(1, "sample_8f3");

    // Two samples, order and padding
    push(12'h123);
    push(12'hABC);
    start_drain();
    finish_drain(2, "two_samples");

    // Back-pressure before the first byte plus an ignored send
    hold_busy = 1'b1;
    push(DW'($urandom));
    start_drain();
    repeat (20) @(negedge clk);
    pulse_send();
    repeat (30) @(negedge clk);
    chk("bp_no_start", q_s.size() - b_qs, 0);
    hold_busy = 1'b0;
    finish_drain(1, "backpressure");
    repeat (5) @(negedge clk);
    chk("bp_send_ignored", n_done_s - b_done_s, 1);
    chk("bp_no_extra_read", n_rd_s - b_rd_s, 1);

    // Reset while waiting on the second byte
    busy_len = 10;
    v1 = DW'($urandom);
    v2 = DW'($urandom);
    fifo_put(v1);
    fifo_put(v2);
    add_exp(v2);
    start_drain();
    k = 0;
    while (q_s.size() - b_qs < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reached", (q_s.size() - b_qs >= 2), 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start", start_s, 1'b0);
    chk("midrst_rd", rd_s, 1'b0);
    chk("midrst_busy", busy_s, 1'b0);
    chk("midrst_done", done_s, 1'b0);
    chk("midrst_data", data_s, 8'h00);
    chk("midrst_cnt", cnt_s, 10'h0);
    rst = 1'b0;
    s0 = q_s.size();
    r0 = n_rd_s;
    repeat (30) @(negedge clk);
    chk("midrst_no_start", q_s.size() - s0, 0);
    chk("midrst_no_read", n_rd_s - r0, 0);
    start_drain();
    finish_drain(1, "after_reset");

    // Randomized drains, including busy that never rises
    for (int r = 0; r < 4; r++) begin
      busy_len = $urandom_range(0, 12);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push(DW'($urandom));
      start_drain();
      finish_drain(n, "random");
    end

    chk("protocol_violations", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
